// File: rtl/decoder_pkg.sv
// decoder_pkg -- shared decoder / execute-stage types.
//   mul_op_t    : RV32M multiply-group operation select from the decoder
//   mul_state_t : control states of the iterative multiplier (mul_seq)
//   MUL_ITER    : partial-product iterations for a full-width multiply
// Helper functions classify each mul_op_t by operand signedness and by
// which half of the 2*XLEN product is returned.
package decoder_pkg;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'd0,
      MUL_OP_MULH   = 2'd1,
      MUL_OP_MULHSU = 2'd2,
      MUL_OP_MULHU  = 2'd3
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   localparam int unsigned MUL_ITER = 32;

   function automatic logic op_a_signed(input mul_op_t op);
      return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
   endfunction

   function automatic logic op_b_signed(input mul_op_t op);
      return (op == MUL_OP_MULH);
   endfunction

   // MUL returns the low word; every other op returns the high word.
   function automatic logic op_high_word(input mul_op_t op);
      return (op != MUL_OP_MUL);
   endfunction

endpackage

// File: rtl/mul_seq.sv
// mul_seq -- iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// One partial product per RUN cycle on operand magnitudes; the sign is
// reapplied with a 2*XLEN negate when leaving RUN.
//
// Ports:
//   clk     in  rising-edge clock
//   reset_n in  asynchronous active-low reset
//   start   in  request a multiply (accepted in IDLE/DONE when kill is low)
//   kill    in  abort; wins over start, suppresses done, keeps result
//   op      in  mul_op_t, sampled with start
//   a, b    in  rs1/rs2 operands, sampled with start
//   busy    out state is RUN
//   done    out one-cycle pulse, result valid
//   result  out product word, held until the next done
//
// Build option: MUL_SEQ_EARLY_EXIT_EN -- also leave RUN once the remaining
// multiplier bits are all zero (results unchanged, latency data dependent).
module mul_seq
   import decoder_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            kill,
   input  mul_op_t         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CNT_W = $clog2(MUL_ITER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

   mul_state_t state, state_nxt;

   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplier;
   logic [CNT_W-1:0]  cnt;
   logic              neg;
   mul_op_t           op_q;

   logic              accept;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] acc_step, acc_final;
   logic              run_last;

   assign accept = start && !kill && ((state == IDLE) || (state == DONE));

   // Operand conditioning: magnitudes plus product sign. The most negative
   // value negates to itself, which is its correct unsigned magnitude.
   always_comb begin
      a_neg = op_a_signed(op) & a[XLEN-1];
      b_neg = op_b_signed(op) & b[XLEN-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
   end

   // One partial-product step and the signed fix-up of its outcome.
   always_comb begin
      acc_step  = mplier[0] ? (acc + mcand) : acc;
      acc_final = neg ? -acc_step : acc_step;
   end

   always_comb begin
      run_last = (cnt == CNT_LAST);
`ifdef MUL_SEQ_EARLY_EXIT_EN
      // Nothing left to add after this step once the shifted multiplier is zero.
      if (mplier[XLEN-1:1] == '0) begin
         run_last = 1'b1;
      end
`endif
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (run_last) state_nxt = DONE;
         DONE:    state_nxt = accept ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
      if (kill) begin
         state_nxt = IDLE;
      end
   end

   // Outputs decoded from state
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         op_q   <= MUL_OP_MUL;
         result <= '0;
      end else if (accept) begin
         acc    <= '0;
         mcand  <= (2*XLEN)'(a_mag);
         mplier <= b_mag;
         cnt    <= '0;
         neg    <= a_neg ^ b_neg;
         op_q   <= op;
      end else if ((state == RUN) && !kill) begin
         acc    <= acc_step;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
         if (run_last) begin
            result <= op_high_word(op_q) ? acc_final[2*XLEN-1:XLEN]
                                         : acc_final[XLEN-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq -- self-checking bench for mul_seq against a 64-bit
// arithmetic reference model (product and done-cycle latency).
module tb_mul_seq;
   import decoder_pkg::*;

`ifdef MUL_SEQ_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   mul_op_t     op = MUL_OP_MUL;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done;
   logic [31:0] result;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_res = '0;

   mul_seq #(.XLEN(32)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start),
      .kill   (kill),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Reference: full product from sign/zero-extended operands.
   function automatic logic [31:0] ref_result(input mul_op_t o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] ex, ey, p;
      ex = (o == MUL_OP_MULH || o == MUL_OP_MULHSU) ? {{32{x[31]}}, x} : {32'h0, x};
      ey = (o == MUL_OP_MULH) ? {{32{y[31]}}, y} : {32'h0, y};
      p  = ex * ey;
      return (o == MUL_OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   // Reference: cycle of done, counting the accept cycle as 0.
   function automatic int ref_done_cycle(input mul_op_t o, input logic [31:0] y);
      logic [31:0] m;
      int n;
      if (!EARLY) return 33;
      m = (o == MUL_OP_MULH && y[31]) ? (32'h0 - y) : y;
      n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      if (n < 1) n = 1;
      return n + 1;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'h1 << $urandom_range(0, 31);
         default: return $urandom;
      endcase
   endfunction

   // Drives one operation (entered #1 after a rising edge) and reports when
   // done came back. Operands are scrambled after acceptance.
   task automatic run_op(input mul_op_t o, input logic [31:0] x, input logic [31:0] y,
                         output int dcyc, output int bcnt, output logic [31:0] res);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op = mul_op_t'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      dcyc = -1; bcnt = 0; res = result;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            dcyc = c; res = result;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; kill = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h exp 0", result); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      last_res = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      mul_op_t     ops [5] = '{MUL_OP_MUL, MUL_OP_MULHU, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULH};
      logic [31:0] xs  [5] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0] ys  [5] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h8000_0000};
      logic [31:0] exp [5] = '{32'd42, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h4000_0000};
      int dcyc, bcnt, edc;
      logic [31:0] res;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], xs[i], ys[i], dcyc, bcnt, res);
         edc = ref_done_cycle(ops[i], ys[i]);
         checks++; if (dcyc != edc) begin errors++; $display("FAIL dir%0d_done_cycle: got %0d exp %0d", i, dcyc, edc); end
         checks++; if (res !== exp[i]) begin errors++; $display("FAIL dir%0d_result: got %h exp %h", i, res, exp[i]); end
         checks++; if (bcnt != edc - 1) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d exp %0d", i, bcnt, edc - 1); end
         last_res = exp[i];
      end
   endtask

   task automatic test_random();
      int dcyc, bcnt, edc;
      logic [31:0] res, x, y, er;
      mul_op_t o;
      for (int i = 0; i < 24; i++) begin
         o = mul_op_t'($urandom_range(0, 3));
         x = pick_operand();
         y = pick_operand();
         run_op(o, x, y, dcyc, bcnt, res);
         er  = ref_result(o, x, y);
         edc = ref_done_cycle(o, y);
         checks++; if (res !== er) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h exp %h", i, o, x, y, res, er); end
         checks++; if (dcyc != edc) begin errors++; $display("FAIL rnd%0d_done_cycle: got %0d exp %0d", i, dcyc, edc); end
         last_res = er;
      end
   endtask

   task automatic test_back_to_back();
      int l1, l2, d1, d2, ndone;
      logic [31:0] r1, r2;
      l1 = ref_done_cycle(MUL_OP_MUL, 32'd5);
      l2 = ref_done_cycle(MUL_OP_MUL, 32'd2);
      d1 = -1; d2 = -1; ndone = 0; r1 = '0; r2 = '0;
      op = MUL_OP_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 150; c++) begin
         start = 1'b0;
         if (c == l1) begin
            op = MUL_OP_MUL; a = 32'd2; b = 32'd2; start = 1'b1;
         end else if (c == 10 && c < l1) begin
            op = MUL_OP_MUL; a = 32'd9; b = 32'd9; start = 1'b1;
         end
         @(negedge clk);
         if (done) begin
            ndone++;
            if (d1 < 0) begin d1 = c; r1 = result; end
            else begin d2 = c; r2 = result; end
         end
         @(posedge clk); #1;
         if (d2 >= 0) break;
      end
      start = 1'b0;
      checks++; if (d1 != l1) begin errors++; $display("FAIL b2b_done1_cycle: got %0d exp %0d", d1, l1); end
      checks++; if (r1 !== 32'd15) begin errors++; $display("FAIL b2b_result1: got %0d exp 15", r1); end
      checks++; if (d2 != l1 + l2) begin errors++; $display("FAIL b2b_done2_cycle: got %0d exp %0d", d2, l1 + l2); end
      checks++; if (r2 !== 32'd4) begin errors++; $display("FAIL b2b_result2: got %0d exp 4", r2); end
      checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_done_count: got %0d exp 2", ndone); end
      last_res = 32'd4;
      @(posedge clk); #1;
   endtask

   task automatic test_kill();
      int ndone, nbusy;
      op = MUL_OP_MULHU; a = $urandom | 32'h1; b = 32'hF000_0001; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0;
      for (int c = 1; c <= 60; c++) begin
         kill = (c == 12);
         @(negedge clk);
         if (done) ndone++;
         if (c == 12) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kill_busy_before: got %b exp 1", busy); end
         end
         if (c == 13) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_idle_after: got busy %b exp 0", busy); end
         end
         @(posedge clk); #1;
      end
      kill = 1'b0;
      checks++; if (ndone != 0) begin errors++; $display("FAIL kill_no_done: got %0d dones exp 0", ndone); end
      checks++; if (result !== last_res) begin errors++; $display("FAIL kill_result_kept: got %h exp %h", result, last_res); end

      // kill together with start: nothing is accepted
      op = MUL_OP_MUL; a = 32'd5; b = 32'd5; start = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0;
      ndone = 0; nbusy = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy) nbusy++;
         @(posedge clk); #1;
      end
      checks++; if (nbusy != 0) begin errors++; $display("FAIL kill_start_busy: got %0d busy cycles exp 0", nbusy); end
      checks++; if (ndone != 0) begin errors++; $display("FAIL kill_start_done: got %0d dones exp 0", ndone); end
      checks++; if (result !== last_res) begin errors++; $display("FAIL kill_start_result: got %h exp %h", result, last_res); end
   endtask

   task automatic test_reset_mid_op();
      int dcyc, bcnt;
      logic [31:0] res;
      run_op(MUL_OP_MUL, 32'd7, 32'd6, dcyc, bcnt, res);
      last_res = 32'd42;
      op = MUL_OP_MULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #3;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b exp 1", busy); end
      checks++; if (result !== last_res) begin errors++; $display("FAIL rst_mid_result_before: got %h exp %h", result, last_res); end
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b exp 0", done); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h exp 0", result); end
      last_res = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_early_exit();
      mul_op_t     ops [3] = '{MUL_OP_MUL, MUL_OP_MUL, MUL_OP_MULHU};
      logic [31:0] xs  [3] = '{32'h1234_5678, 32'd9, 32'hDEAD_BEEF};
      logic [31:0] ys  [3] = '{32'h0, 32'h1, 32'h100};
      int dcyc, bcnt, edc;
      logic [31:0] res, er;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], xs[i], ys[i], dcyc, bcnt, res);
         edc = ref_done_cycle(ops[i], ys[i]);
         er  = ref_result(ops[i], xs[i], ys[i]);
         checks++; if (dcyc != edc) begin errors++; $display("FAIL early%0d_done_cycle: got %0d exp %0d", i, dcyc, edc); end
         checks++; if (res !== er) begin errors++; $display("FAIL early%0d_result: got %h exp %h", i, res, er); end
         last_res = er;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_kill();
      test_early_exit();
      test_random();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative shift-add multiplier for the RV32M multiply group: MUL, MULH, MULHSU, MULHU. It sits directly downstream of the decoder in the core's execute stage. It consumes the decoder's `mul_op_t` selection plus the two register operands, and produces a 32-bit result for the `WB_MUL` writeback path. It trades latency for area: one partial product per cycle, with a start/done handshake that the core uses to stall.

## Interface

Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is verified.

Ports:
- `clk`  in  1  the only clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; sampled only when the block can accept.
- `kill`  in  1  abort the current operation (branch flush or interrupt entry).
- `op`  in  `mul_op_t`  operation select, sampled with `start`.
- `a`  in  XLEN  rs1 operand, sampled with `start`.
- `b`  in  XLEN  rs2 operand, sampled with `start`.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  XLEN  product word; held until the next `done`.

## Operation

- States (`mul_state_t`):
  - IDLE
  - RUN
  - DONE
- `start` is accepted when the state is IDLE or DONE and `kill` is low. Accepting a start gives RUN on the next cycle. `start` in RUN is ignored.
- Operand conditioning at accept:
  - `a` is signed for MULH and MULHSU; `b` is signed for MULH only.
  - Each signed operand is replaced by its magnitude; 0x8000_0000 gives magnitude 0x8000_0000 (unsigned).
  - `neg` = sign(a) XOR sign(b), counting only the operands that are signed.
  - MUL is treated as unsigned; the low word is sign-agnostic.
- Each RUN cycle:
  - if multiplier bit 0 is set, add the multiplicand to the 2·XLEN accumulator;
  - shift the multiplicand left by 1 and the multiplier right by 1;
  - increment the 5-bit counter.
- Leaving RUN:
  - on the cycle the counter reaches 31, the next state is DONE;
  - the final accumulator is two's-complement negated (64-bit) if `neg` is set;
  - `result` is loaded with the low word for MUL and the high word otherwise.
- In DONE, `done` is 1 for exactly this cycle. The next state is IDLE, or RUN if a new `start` is accepted.
- `kill` in any state: the next state is IDLE, no `done` is produced, and `result` is unchanged. If `kill` and `start` arrive in the same cycle, `kill` wins and the start is dropped.
- `busy` = (state == RUN).

## Timing

- Reset values:
  - state IDLE;
  - `busy` 0, `done` 0, `result` 0;
  - accumulator, counter and operand registers 0.
- Latency (with `start` accepted in cycle 0):
  - RUN occupies cycles 1..32;
  - `done` and a valid `result` appear in cycle 33;
  - a new `start` accepted in cycle 33 gives `done` in cycle 66.
- Throughput: one operation every 33 cycles when issued back-to-back.
- Reset asserted mid-operation forces all outputs to their reset values immediately (asynchronous).
- `op`, `a` and `b` may change freely after acceptance; they are not sampled again.

## Configuration

- Macro: `MUL_SEQ_EARLY_EXIT_EN`.
- Defined:
  - the RUN→DONE transition also fires when the shifted multiplier magnitude becomes zero;
  - RUN length = max(1, index of the MSB of |b| + 1) cycles;
  - `b` = 0 gives RUN for 1 cycle and `done` in cycle 2;
  - results are identical to the fixed-latency build.
- Undefined: RUN always lasts 32 cycles. The counter alone terminates RUN.

## Structure

- Add `mul_state_t` (IDLE, RUN, DONE) to `decoder_pkg`, next to `mul_op_t`.
- Add the constant `MUL_ITER = 32` to `decoder_pkg`.
- Single flat module, no sub-module. Operand conditioning and the final negate are small combinational blocks inside `mul_seq`.

## Test plan

- MUL, a=7, b=6: `done` in cycle 33 (fixed build), `result` = 42; `busy` high in cycles 1..32.
- MULHU, a=b=0xFFFF_FFFF: `result` = 0xFFFF_FFFE. MULH, a=b=0xFFFF_FFFF: `result` = 0x0000_0000.
- MULHSU, a=0xFFFF_FFFF, b=2: `result` = 0xFFFF_FFFF. MULH, a=b=0x8000_0000: `result` = 0x4000_0000.
- Back-to-back: MUL 3×5 then a new start in the `done` cycle with MUL 2×2. Required: `done` in cycle 33 with `result` 15, then `done` in cycle 66 with `result` 4. A `start` pulsed in cycle 10 is ignored.
- Kill: `kill` in cycle 12 gives IDLE in cycle 13, no `done`, and `result` keeps its previous value. `kill` and `start` together give no operation. Reset asserted in cycle 20 clears all outputs immediately.
- Early exit with `MUL_SEQ_EARLY_EXIT_EN` defined:
  - b=0 gives `done` in cycle 2, `result` 0;
  - b=1, a=9 gives `done` in cycle 2, `result` 9;
  - b=0x100 gives `done` in cycle 10.
